roachf_input_select_core: RTL
=============================

// Module: roachf_input_select_core
// PURPOSE
//  Consumer of the input_selector software register (32-bit control word, already in user_clk
//  domain). Routes NUM_IN ADC sample buses onto NUM_OUT F-engine input streams, or substitutes
//  zero / ramp / constant test data. Config changes apply glitch-free, aligned to the PFB sync
//  pulse, so every spectrum is built from a single configuration.
// PARAMETERS
//  NUM_IN   4    ADC input buses (2-bit select field per output)
//  NUM_OUT  2    output streams (fixed at 2 by control-word layout)
//  DATA_W   32   bits per bus: 4 lanes x 8-bit two's-complement samples, lane 0 = [7:0]
//  CNT_W    16   width of switch_count
// PORTS
//  user_clk      in   1            sole clock
//  user_rst_n    in   1            async active-low reset
//  ctrl_word     in   32           register value: [1:0] sel0, [3:2] sel1, [5:4] mode0, [7:6] mode1,
//                                  [15:8] const byte, [31] immediate; others ignored
//  din           in   NUM_IN*32    input bus i at [32i+31:32i]
//  din_valid     in   1            qualifies din, common to all inputs
//  sync_in       in   1            one-cycle sync pulse, coincident with din
//  dout          out  NUM_OUT*32   output stream j at [32j+31:32j]
//  dout_valid    out  1            din_valid delayed 2 cycles
//  sync_out      out  1            sync_in delayed 2 cycles
//  cfg_pending   out  1            new config captured, not yet active
//  switch_count  out  CNT_W        number of configs applied, wraps
// BEHAVIOUR
//  Reset: dout=0, dout_valid=0, sync_out=0, cfg_pending=0, switch_count=0, ramps=0,
//   active cfg = sel0=0, sel1=1, modes=00, const=0x00, FSM=IDLE.
//  Capture: ctrl_q <= ctrl_word each cycle. "Change" = ctrl_q[31,15:0] != active cfg.
//  FSM (ignored bits never cause a change):
//   IDLE : change -> STAB, latch cand = ctrl_q.
//   STAB : ctrl_q == cand this cycle -> cand[31] ? APPLY : ARMED; else re-latch, stay STAB.
//          (debounce against torn register writes; >=1 cycle of stable value required)
//   ARMED: cfg_pending=1. sync_in=1 -> APPLY. ctrl_q != cand -> STAB with new cand.
//   APPLY: active <= cand, switch_count++, ramps cleared -> IDLE (one cycle). Any newer
//          value is caught by IDLE next cycle.
//  Alignment: with APPLY entered from ARMED on sync_in, the din beat carrying sync_in
//   and all after it use the new cfg; earlier beats use the old cfg.
//  cfg_pending=1 in STAB and ARMED, 0 in IDLE/APPLY.
//  Datapath, per output j, 2-stage registered, latency exactly 2 cycles:
//   mode 00: din bus sel_j          mode 01: all zeros
//   mode 10: ramp: lanes = r, r+1, r+2, r+3 (8-bit, mod 256); r += 4 on each valid beat;
//            r cleared to 0 on APPLY and on each sync_in beat
//   mode 11: const byte replicated to all 4 lanes
//  sel_j >= NUM_IN -> output zeros. Two outputs selecting the same input is legal.
//  din_valid=0: pipeline still advances; ramps do not increment; dout follows datapath.
//  sync_in while din_valid=0: still propagated, still clears ramps.
//  Async reset mid-operation: all state to reset values immediately; a pending cfg is
//   lost and re-detected after reset release (ctrl_word still differs from reset cfg).
// TESTING
//  1 Reset, ctrl_word=0x00000004, din0=0x03020100, din1=0x13121110 -> no switch until
//    sync; on the sync beat + 2 cycles dout[63:32]=din1 (sel1=1), switch_count=1.
//  2 ctrl_word=0x80000001 -> applied without sync, sel0=1; dout[31:0]=din1 from 2 beats
//    after apply; cfg_pending high exactly 1 cycle.
//  3 ctrl_word=0x00000020 (mode0=ramp), continuous valid -> dout[31:0]=0x03020100,
//    0x07060504,...; wraps 0xFFFEFDFC -> 0x03020100; resets to 0x03020100 on sync beat.
//  4 ctrl_word toggles 0x1 -> 0x2 -> 0x1 on successive cycles while ARMED -> single apply
//    on next sync with final value, switch_count +1 only.
//  5 ctrl_word=0x0000AAF0 (both const, 0xAA) -> dout=0xAAAAAAAA_AAAAAAAA after sync;
//    bits [30:16] toggled alone -> no pending, no switch.
//  6 Assert user_rst_n low while ARMED -> outputs/counters 0 asynchronously; after
//    release, pending re-raised and applied on next sync.

Source files
------------

// File: rtl/roachf_input_select_core.sv
// ---------------------------------------------------------------------------
// roachf_input_select_core
//
// Routes NUM_IN ADC sample buses onto NUM_OUT F-engine input streams, or
// substitutes zero / ramp / constant test data. A new control word is
// debounced, held pending, and switched in on the PFB sync pulse so that
// every spectrum is built from a single configuration. Words with the
// immediate bit set are applied as soon as they are stable.
//
// Ports
//   user_clk      sole clock
//   user_rst_n    asynchronous active-low reset
//   ctrl_word     [1:0] sel0, [3:2] sel1, [5:4] mode0, [7:6] mode1,
//                 [15:8] constant byte, [31] immediate; other bits ignored
//   din           NUM_IN sample buses, bus i at [32i+31:32i]
//   din_valid     qualifies din (common to all inputs)
//   sync_in       one-cycle sync pulse, coincident with din
//   dout          NUM_OUT output streams, stream j at [32j+31:32j]
//   dout_valid    din_valid delayed 2 cycles
//   sync_out      sync_in delayed 2 cycles
//   cfg_pending   a new configuration is captured but not yet active
//   switch_count  number of configurations applied (wraps)
// ---------------------------------------------------------------------------
module roachf_input_select_core #(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 2,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                      user_clk,
    input  logic                      user_rst_n,
    input  logic [31:0]               ctrl_word,
    input  logic [NUM_IN*DATA_W-1:0]  din,
    input  logic                      din_valid,
    input  logic                      sync_in,
    output logic [NUM_OUT*DATA_W-1:0] dout,
    output logic                      dout_valid,
    output logic                      sync_out,
    output logic                      cfg_pending,
    output logic [CNT_W-1:0]          switch_count
);

    // Configuration is kept as {immediate, ctrl_word[15:0]}; bits [30:16]
    // are never stored, so they can never look like a change.
    localparam logic [16:0] RESET_CFG = 17'h00004;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STAB  = 2'd1,
        ARMED = 2'd2,
        APPLY = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [16:0] ctrl_q;
    logic [16:0] cand;
    logic [16:0] active;
    logic [16:0] eff_cfg;
    logic        load_cand;
    logic        do_apply;
    logic        ctrl_unused;

    logic [NUM_IN*DATA_W-1:0] s1_din;
    logic                     s1_valid;
    logic                     s1_sync;
    logic [7:0]               ramp      [NUM_OUT];
    wire  [7:0]               ramp_next [NUM_OUT];
    wire  [NUM_OUT*DATA_W-1:0] dout_next;

    assign ctrl_unused = ^ctrl_word[30:16];

    // The captured word resets to zero (not to the reset configuration), so
    // whatever the register holds after reset is re-detected and applied.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= {ctrl_word[31], ctrl_word[15:0]};
        end
    end

    // STAB requires the candidate to be seen unchanged for a cycle, which
    // filters out torn register writes. ARMED gives sync priority over a
    // late change so the switch stays aligned to the sync beat.
    always_comb begin
        next_state  = state;
        load_cand   = 1'b0;
        do_apply    = 1'b0;
        cfg_pending = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_q != active) begin
                    next_state = STAB;
                    load_cand  = 1'b1;
                end
            end
            STAB: begin
                cfg_pending = 1'b1;
                if (ctrl_q == cand) begin
                    next_state = cand[16] ? APPLY : ARMED;
                end else begin
                    load_cand = 1'b1;
                end
            end
            ARMED: begin
                cfg_pending = 1'b1;
                if (sync_in) begin
                    next_state = APPLY;
                end else if (ctrl_q != cand) begin
                    next_state = STAB;
                    load_cand  = 1'b1;
                end
            end
            APPLY: begin
                do_apply   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state        <= IDLE;
            cand         <= RESET_CFG;
            active       <= RESET_CFG;
            switch_count <= '0;
        end else begin
            state <= next_state;
            if (load_cand) begin
                cand <= ctrl_q;
            end
            if (do_apply) begin
                active       <= cand;
                switch_count <= switch_count + 1'b1;
            end
        end
    end

    // While in APPLY the beat in the second stage is the one that carried
    // the sync pulse, so it already has to see the candidate configuration.
    assign eff_cfg = do_apply ? cand : active;

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
        logic [1:0]        sel;
        logic [1:0]        mode;
        logic [7:0]        base;
        logic [DATA_W-1:0] stream;

        assign sel  = eff_cfg[2*j +: 2];
        assign mode = eff_cfg[4+2*j +: 2];
        // The sync beat and the apply beat both restart the ramp at zero.
        assign base = (do_apply || s1_sync) ? 8'd0 : ramp[j];
        assign ramp_next[j] = s1_valid ? base + 8'd4 : base;

        always_comb begin
            stream = '0;
            case (mode)
                2'b00: begin
                    if (int'(sel) < NUM_IN) begin
                        stream = s1_din[int'(sel)*DATA_W +: DATA_W];
                    end
                end
                2'b01:   stream = '0;
                2'b10:   stream = {base + 8'd3, base + 8'd2, base + 8'd1, base};
                default: stream = {4{eff_cfg[15:8]}};
            endcase
        end

        assign dout_next[j*DATA_W +: DATA_W] = stream;
    end

    // Two pipeline stages: input capture, then selection into the output.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            s1_din     <= '0;
            s1_valid   <= 1'b0;
            s1_sync    <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_out   <= 1'b0;
            for (int j = 0; j < NUM_OUT; j++) begin
                ramp[j] <= 8'd0;
            end
        end else begin
            s1_din     <= din;
            s1_valid   <= din_valid;
            s1_sync    <= sync_in;
            dout       <= dout_next;
            dout_valid <= s1_valid;
            sync_out   <= s1_sync;
            for (int j = 0; j < NUM_OUT; j++) begin
                ramp[j] <= ramp_next[j];
            end
        end
    end

endmodule
